// File: rtl/simd_div_controller.sv
// SIMD unsigned restoring divider: 1x16, 2x8 or 4x4-bit lanes, one quotient bit per lane per cycle.
// Optional SIMD_DIV_SIGNED_EN adds sign_md and a FIX state for two's-complement lanes.
module simd_div_controller #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
`ifdef SIMD_DIV_SIGNED_EN
  input  logic                 sign_md,
`endif
  input  logic                 start,
  input  logic [WIDTH-1:0]     N,
  input  logic [WIDTH-1:0]     D,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic [3:0]           div_by_zero
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned QW = WIDTH / 4;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  q_q, r_q, d_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  nq, nr;
  logic [1:0]        mnorm;
  logic [CW-1:0]     cnt_load;
  logic [WIDTH-1:0]  cap_n, cap_d;

  function automatic logic [3:0] zero_lanes(input logic [WIDTH-1:0] v, input logic [1:0] m);
    zero_lanes = '0;
    case (m)
      2'b01:   for (int unsigned l = 0; l < 2; l++) zero_lanes[l] = (v[l*HW +: HW] == '0);
      2'b10:   for (int unsigned l = 0; l < 4; l++) zero_lanes[l] = (v[l*QW +: QW] == '0);
      default: zero_lanes[0] = (v == '0);
    endcase
  endfunction

`ifdef SIMD_DIV_SIGNED_EN
  logic [3:0]        sn_q, sd_q;
  logic [3:0]        cap_sn, cap_sd;

  function automatic logic [3:0] sign_bits(input logic [WIDTH-1:0] v, input logic [1:0] m);
    case (m)
      2'b01:   sign_bits = {2'b00, v[WIDTH-1], v[HW-1]};
      2'b10:   sign_bits = {v[WIDTH-1], v[3*QW-1], v[2*QW-1], v[QW-1]};
      default: sign_bits = {3'b000, v[WIDTH-1]};
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] lane_cneg(input logic [WIDTH-1:0] v, input logic [3:0] neg,
                                                 input logic [1:0] m);
    lane_cneg = v;
    case (m)
      2'b01: begin
        for (int unsigned l = 0; l < 2; l++)
          if (neg[l]) lane_cneg[l*HW +: HW] = '0 - v[l*HW +: HW];
      end
      2'b10: begin
        for (int unsigned l = 0; l < 4; l++)
          if (neg[l]) lane_cneg[l*QW +: QW] = '0 - v[l*QW +: QW];
      end
      default: if (neg[0]) lane_cneg = '0 - v;
    endcase
  endfunction

  // Zero-divisor lanes keep the raw dividend so they yield the unsigned pattern with no fixup.
  always_comb begin
    cap_sn = sign_md ? (sign_bits(N, mnorm) & ~zero_lanes(D, mnorm)) : '0;
    cap_sd = sign_md ? sign_bits(D, mnorm) : '0;
    cap_n  = lane_cneg(N, cap_sn, mnorm);
    cap_d  = lane_cneg(D, cap_sd, mnorm);
  end
`else
  always_comb begin
    cap_n = N;
    cap_d = D;
  end
`endif

  always_comb begin
    mnorm    = (mode == 2'b11) ? 2'b00 : mode;
    cnt_load = CW'(WIDTH - 1);
    case (mnorm)
      2'b01:   cnt_load = CW'(HW - 1);
      2'b10:   cnt_load = CW'(QW - 1);
      default: cnt_load = CW'(WIDTH - 1);
    endcase
  end

  // One restoring step for each lane split; the latched mode picks which split is used.
  logic [2:0][WIDTH-1:0] stq, str;

  for (genvar c = 0; c < 3; c++) begin : g_cfg
    localparam int unsigned NL = 1 << c;
    localparam int unsigned LW = WIDTH / NL;
    for (genvar g = 0; g < NL; g++) begin : g_lane
      logic [LW-1:0] rl, ql, dl, rs;
      logic          ge;
      assign rl = r_q[g*LW +: LW];
      assign ql = q_q[g*LW +: LW];
      assign dl = d_q[g*LW +: LW];
      assign rs = {rl[LW-2:0], ql[LW-1]};
      assign ge = (rs >= dl);
      assign stq[c][g*LW +: LW] = {ql[LW-2:0], ge};
      assign str[c][g*LW +: LW] = ge ? (rs - dl) : rs;
    end
  end

  always_comb begin
    nq = stq[0];
    nr = str[0];
    case (mode_q)
      2'b01: begin nq = stq[1]; nr = str[1]; end
      2'b10: begin nq = stq[2]; nr = str[2]; end
      default: begin nq = stq[0]; nr = str[0]; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: begin
        if (cnt_q == '0) begin
`ifdef SIMD_DIV_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      result      <= '0;
      div_by_zero <= '0;
`ifdef SIMD_DIV_SIGNED_EN
      sn_q        <= '0;
      sd_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q <= mnorm;
            q_q    <= cap_n;
            r_q    <= '0;
            d_q    <= cap_d;
            cnt_q  <= cnt_load;
`ifdef SIMD_DIV_SIGNED_EN
            sn_q   <= cap_sn;
            sd_q   <= cap_sd;
`endif
          end
        end
        S_CALC: begin
          q_q   <= nq;
          r_q   <= nr;
          cnt_q <= cnt_q - CW'(1);
`ifndef SIMD_DIV_SIGNED_EN
          if (cnt_q == '0) begin
            result      <= {nr, nq};
            div_by_zero <= zero_lanes(d_q, mode_q);
          end
`endif
        end
`ifdef SIMD_DIV_SIGNED_EN
        S_FIX: begin
          result      <= {lane_cneg(r_q, sn_q, mode_q), lane_cneg(q_q, sn_q ^ sd_q, mode_q)};
          div_by_zero <= zero_lanes(d_q, mode_q);
        end
`endif
        default: ;
      endcase
    end
  end

  assign done = (state_q == S_DONE);
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_simd_div_controller.sv
// Self-checking bench for simd_div_controller: directed vectors plus randomized operations
// compared against a lane-wise arithmetic reference model.
module tb_simd_div_controller;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        start;
  logic [15:0] N, D;
  logic [31:0] result;
  logic        done, busy;
  logic [3:0]  div_by_zero;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  simd_div_controller #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .N(N), .D(D),
    .result(result), .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lane_w(input logic [1:0] m);
    return (m == 2'b01) ? 8 : (m == 2'b10) ? 4 : 16;
  endfunction

  // Reference: per lane q = n/d, r = n%d; divide by zero gives q = all ones, r = n.
  function automatic logic [35:0] ref_div(input logic [1:0] m, input logic [15:0] n, input logic [15:0] d);
    int unsigned lw, nl, mask, nv, dv, qv, rv;
    logic [15:0] q, r;
    logic [3:0]  z;
    lw = lane_w(m);
    nl = 16 / lw;
    mask = (32'd1 << lw) - 1;
    q = '0; r = '0; z = '0;
    for (int unsigned l = 0; l < nl; l++) begin
      nv = (32'(n) >> (l * lw)) & mask;
      dv = (32'(d) >> (l * lw)) & mask;
      if (dv == 0) begin
        qv = mask; rv = nv; z[l] = 1'b1;
      end else begin
        qv = nv / dv; rv = nv % dv;
      end
      q = q | 16'(qv << (l * lw));
      r = r | 16'(rv << (l * lw));
    end
    return {z, r, q};
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [15:0] n, input logic [15:0] d,
                        input bit garble, input string tag);
    logic [35:0] exp;
    int unsigned lat;
    exp = ref_div(m, n, d);
    @(negedge clk);
    mode = m; N = n; D = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (garble) begin
      N = 16'($urandom); D = 16'($urandom); mode = 2'($urandom);
    end
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && garble) begin
        N = 16'($urandom); D = 16'($urandom); mode = 2'($urandom); start = 1'($urandom);
      end
    end
    start = 1'b0;
    check({tag, " latency"}, lat, lane_w(m));
    check({tag, " result"}, result, exp[31:0]);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(exp[35:32]));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " result hold"}, result, exp[31:0]);
  endtask

  initial begin
    logic [35:0] e;
    int unsigned last, waited, pulses;
    rst = 1'b1; start = 1'b0; mode = 2'b00; N = '0; D = '0;
    repeat (2) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op(2'b00, 16'h7536, 16'h0007, 1'b0, "m00");
    check("m00 const", result, 32'h0004_10BE);
    run_op(2'b01, 16'h7536, 16'h0705, 1'b0, "m01");
    check("m01 const", result, 32'h0504_100A);
    run_op(2'b10, 16'h7536, 16'h3120, 1'b0, "m10");
    check("m10 const", result, 32'h1016_251F);
    check("m10 dbz const", 32'(div_by_zero), 32'h1);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, "ffff");
    check("ffff const", result, 32'h0000_0001);
    run_op(2'b00, 16'h0003, 16'h0010, 1'b0, "small");
    check("small const", result, 32'h0003_0000);
    run_op(2'b11, 16'h7536, 16'h0007, 1'b0, "m11");

    // start held high: done every 6 cycles; inputs disturbed mid-CALC then restored
    e = ref_div(2'b10, 16'h9C4B, 16'h2314);
    @(negedge clk);
    mode = 2'b10; N = 16'h9C4B; D = 16'h2314; start = 1'b1;
    waited = 0;
    while (!done && waited < 20) begin @(negedge clk); waited++; end
    check("held first done", 32'(done), 32'd1);
    last = cyc;
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      N = 16'($urandom); D = 16'($urandom); mode = 2'($urandom);
      repeat (2) @(negedge clk);
      mode = 2'b10; N = 16'h9C4B; D = 16'h2314;
      waited = 0;
      while (!done && waited < 20) begin @(negedge clk); waited++; end
      check("held period", cyc - last, 32'd6);
      check("held result", result, e[31:0]);
      last = cyc;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-CALC aborts with no done and clears result
    @(negedge clk);
    mode = 2'b00; N = 16'h1234; D = 16'h0005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", result, 32'd0);
    check("abort done", 32'(done), 32'd0);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done) pulses++; end
    check("abort no done", pulses, 0);
    run_op(2'b00, 16'h1234, 16'h0005, 1'b0, "after abort");

    for (int i = 0; i < 30; i++) begin
      logic [15:0] rn, rd;
      rn = 16'($urandom);
      rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd & 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd & 16'hF0F0;
      run_op(2'($urandom), rn, rd, bit'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
